alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational 16-bit datapath ALU.
- Keeps the 8-bit opcode map. Adds a persistent flag register (PSR), a real carry chain for ADDC, and correct signed-overflow and compare flags.
- Adds a serial multi-cycle shifter and valid/ready handshakes on both sides.
- Sits between the register-file read stage and the writeback mux. The PSR output feeds the branch/condition unit.

Parameters:
- WIDTH, 16, datapath width in bits (>=4).
- SHW, $clog2(WIDTH)+1, width of the internal shift counter (derived, not overridable).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept an operation this cycle
- r1  in  WIDTH  operand A (shift amount for shifts)
- r2  in  WIDTH  operand B (shifted value for shifts)
- opcode  in  8  operation select
- out_valid  out  1  rout/flags/err valid
- out_ready  in  1  consumer takes the result
- rout  out  WIDTH  result
- flags  out  8  PSR: bit0 C, bit2 L, bit5 F, bit6 Z, bit7 N; other bits always 0
- err  out  1  illegal opcode, qualified by out_valid

Behaviour:
- Reset: state IDLE, rout=0, flags=0, out_valid=0, err=0.
- Reset mid-shift abandons the operation; no partial result is delivered.
- in_ready = (state==IDLE) && (!out_valid || out_ready). An operation is accepted on in_valid && in_ready.
- Output register holds rout/flags/err stable while out_valid && !out_ready.
- Single-cycle ops (all non-shift opcodes):
  - Accept at edge T; out_valid=1 after edge T+1.
  - PSR updates on the same edge, so a back-to-back op accepted at T+1 sees the new C.
- Opcodes and flags (flags not listed keep their value):
  - 0x05 ADD: rout=r1+r2; C=carry out; F=(r1[MSB]==r2[MSB]) && (rout[MSB]!=r1[MSB]).
  - 0x06 ADDU: rout=r1+r2; C=carry out.
  - 0x07 ADDC: rout=r1+r2+PSR.C at accept; C=carry out; F as ADD.
  - 0x09 SUB: rout=r1+~r2+1; C=carry out (1 = no borrow); F=(r1[MSB]!=r2[MSB]) && (rout[MSB]!=r1[MSB]).
  - 0x0B CMP: rout=r1-r2; Z=(r1==r2); L=(r1<r2 unsigned); N=(r1<r2 signed); C and F unchanged.
  - 0x01 AND, 0x02 OR, 0x03 XOR, 0x04 NOT (~r1): flags unchanged.
  - Shifts, value r2, amount r1 (unsigned): 0x84 LSH, 0x08 RSH (logical), 0x0C ALSH (= LSH), 0x0F ARSH (sign fill). Flags unchanged.
  - Any other opcode: rout=0, err=1, flags unchanged, 1-cycle latency.
- Shift FSM: IDLE -> SHIFT -> IDLE.
  - On accept: k = min(r1, WIDTH). Load k into the counter and r2 into the working register.
  - k==0: result delivered as a 1-cycle op, SHIFT skipped.
  - SHIFT: one bit position per cycle. Count reaches 0 -> load output, return to IDLE.
  - Latency = 1+k cycles from accept to out_valid; maximum 1+WIDTH.
  - r1>=WIDTH: LSH/RSH/ALSH give 0; ARSH gives all copies of r2[MSB].
  - Operands are captured at accept; later changes on r1/r2/opcode have no effect.
- Backpressure: entering SHIFT requires the output slot to be free or draining at accept (in_ready rule). A finished shift therefore never finds out_valid stuck high.
- All arithmetic is WIDTH bits with a WIDTH+1-bit internal sum for carry. Wrap-around is silent apart from the C and F flags.

Decomposition:
- Shared package alu_pkg: opcode localparams (OP_ADD..OP_NOT), PSR bit-index constants (FLG_C=0, FLG_L=2, FLG_F=5, FLG_Z=6, FLG_N=7), FSM state encoding.
- One natural sub-module: alu_serial_shifter. It holds the counter, the working register and a done pulse, and takes direction/arithmetic/start inputs.
- The top-level alu_seq holds the handshake, the single-cycle datapath and the PSR.

Test Plan:
- ADD 0x7FFF+0x0001 -> rout=0x8000, C=0, F=1, out_valid 1 cycle after accept. Then ADD 0xFFFF+0x0001 -> rout=0x0000, C=1, F=0.
- ADDU 0xFFFF+0x0002 (C=1), immediately followed by ADDC 0x0000+0x0000 on the next cycle -> rout=0x0001.
- CMP r1=0xFFFE, r2=0x0001 -> Z=0, L=0, N=1, C/F unchanged. CMP 0x1234,0x1234 -> Z=1, L=0, N=0.
- ARSH r2=0x8000, r1=3 -> rout=0xF000, out_valid exactly 4 cycles after accept, in_ready low during SHIFT. LSH r1=20 -> rout=0x0000 after 17 cycles.
- Hold out_ready=0 for 5 cycles after a result -> rout/flags stable, in_ready=0. Opcode 0xAA -> err=1, rout=0, flags unchanged.
- Assert reset during a 10-cycle shift -> next cycle out_valid=0, flags=0, in_ready=1; no stale result appears.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, PSR bit positions,
// and the control FSM encoding.
package alu_pkg;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_NOT  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_RSH  = 8'h08;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_ALSH = 8'h0C;
  localparam logic [7:0] OP_ARSH = 8'h0F;
  localparam logic [7:0] OP_LSH  = 8'h84;

  localparam int FLG_C = 0;
  localparam int FLG_L = 2;
  localparam int FLG_F = 5;
  localparam int FLG_Z = 6;
  localparam int FLG_N = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift_op(input logic [7:0] op);
    return (op == OP_LSH) || (op == OP_ALSH) || (op == OP_RSH) || (op == OP_ARSH);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the register-file read stage,
// the ALU and the writeback mux.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic [7:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rout;
  logic [7:0]       flags;
  logic             err;

  modport master (
    output in_valid, r1, r2, opcode, out_ready,
    input  in_ready, out_valid, rout, flags, err
  );

  modport slave (
    input  in_valid, r1, r2, opcode, out_ready,
    output in_ready, out_valid, rout, flags, err
  );
endinterface

// File: rtl/alu_serial_shifter.sv
// Serial shifter: one bit position per cycle. done_o marks the cycle whose
// edge produces the final value, which is presented on result_o.
module alu_serial_shifter #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_i,
  input  logic                       left_i,
  input  logic                       arith_i,
  input  logic [$clog2(WIDTH):0]     amount_i,
  input  logic [WIDTH-1:0]           value_i,
  output logic                       done_o,
  output logic [WIDTH-1:0]           result_o
);
  localparam int SHW = $clog2(WIDTH) + 1;

  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] work_q;
  logic             left_q;
  logic             arith_q;
  logic [WIDTH-1:0] step;

  always_comb begin
    if (left_q) begin
      step = {work_q[WIDTH-2:0], 1'b0};
    end else begin
      step = {arith_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      work_q  <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (start_i) begin
      cnt_q   <= amount_i;
      work_q  <= value_i;
      left_q  <= left_i;
      arith_q <= arith_i;
    end else if (cnt_q != '0) begin
      cnt_q  <= cnt_q - SHW'(1);
      work_q <= step;
    end
  end

  // The last shift step is handed straight to the output register so that
  // the total latency is exactly 1+k.
  assign done_o   = (cnt_q == SHW'(1));
  assign result_o = step;

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with persistent PSR, carry chain, and a serial shifter behind
// valid/ready handshakes on both the operand and result side.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH) + 1;
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rout_q, rout_d;
  logic [7:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             is_shift;
  logic             sh_left;
  logic             sh_arith;
  logic [SHW-1:0]   sh_amount;
  logic             sh_start;
  logic             sh_done;
  logic [WIDTH-1:0] sh_result;

  logic [WIDTH-1:0] addend;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             ovf;

  logic [WIDTH-1:0] alu_res;
  logic [7:0]       alu_flags;
  logic             alu_err;

  assign bus.in_ready  = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.rout      = rout_q;
  assign bus.flags     = flags_q;
  assign bus.err       = err_q;

  // Shift decode; amounts of WIDTH or more saturate, which flushes the
  // value completely (or fills it with the sign for ARSH).
  always_comb begin
    is_shift  = is_shift_op(bus.opcode);
    sh_left   = (bus.opcode == OP_LSH) || (bus.opcode == OP_ALSH);
    sh_arith  = (bus.opcode == OP_ARSH);
    sh_amount = (bus.r1 >= WIDTH_V) ? SHW'(WIDTH) : bus.r1[SHW-1:0];
  end

  // One adder serves ADD/ADDU/ADDC/SUB/CMP; subtraction is r1 + ~r2 + 1.
  always_comb begin
    addend = bus.r2;
    cin    = 1'b0;
    case (bus.opcode)
      OP_ADDC:        cin = flags_q[FLG_C];
      OP_SUB, OP_CMP: begin
        addend = ~bus.r2;
        cin    = 1'b1;
      end
      default: ;
    endcase
    sum = {1'b0, bus.r1} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
    ovf = (bus.r1[MSB] == addend[MSB]) && (sum[MSB] != bus.r1[MSB]);
  end

  always_comb begin
    alu_res   = '0;
    alu_flags = flags_q;
    alu_err   = 1'b0;
    case (bus.opcode)
      OP_AND:  alu_res = bus.r1 & bus.r2;
      OP_OR:   alu_res = bus.r1 | bus.r2;
      OP_XOR:  alu_res = bus.r1 ^ bus.r2;
      OP_NOT:  alu_res = ~bus.r1;
      OP_ADD, OP_ADDC, OP_SUB: begin
        alu_res          = sum[MSB:0];
        alu_flags[FLG_C] = sum[WIDTH];
        alu_flags[FLG_F] = ovf;
      end
      OP_ADDU: begin
        alu_res          = sum[MSB:0];
        alu_flags[FLG_C] = sum[WIDTH];
      end
      OP_CMP: begin
        alu_res          = sum[MSB:0];
        alu_flags[FLG_Z] = (bus.r1 == bus.r2);
        alu_flags[FLG_L] = (bus.r1 < bus.r2);
        alu_flags[FLG_N] = ($signed(bus.r1) < $signed(bus.r2));
      end
      // Zero-length shift: the value passes through in one cycle.
      OP_LSH, OP_ALSH, OP_RSH, OP_ARSH: alu_res = bus.r2;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rout_d      = rout_q;
    flags_d     = flags_q;
    err_d       = err_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    sh_start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift && (sh_amount != '0)) begin
            sh_start = 1'b1;
            state_d  = ST_SHIFT;
          end else begin
            rout_d      = alu_res;
            flags_d     = alu_flags;
            err_d       = alu_err;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (sh_done) begin
          rout_d      = sh_result;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rout_q      <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rout_q      <= rout_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  alu_serial_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .start_i  (sh_start),
    .left_i   (sh_left),
    .arith_i  (sh_arith),
    .amount_i (sh_amount),
    .value_i  (bus.r2),
    .done_o   (sh_done),
    .result_o (sh_result)
  );

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: an arithmetic reference model predicts every result,
// its PSR and its latency; a negedge process checks each delivered result.
module tb_alu_seq;
  localparam int W = 16;
  localparam int P = 10;

  logic clk = 1'b0;
  logic reset;
  always #(P/2) clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [15:0] rout;
    logic [7:0]  flags;
    logic        err;
    int          lat;
    time         acc_t;
    string       name;
  } exp_t;

  exp_t        q[$];
  bit          head_seen = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  psr = 8'h00;
  logic [15:0] last_rout = 16'h0;
  logic [7:0]  last_flags = 8'h0;
  logic        last_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, got, req);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // Reference model: plain integer arithmetic on the documented opcode rules.
  task automatic model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                       output exp_t e);
    int ia, ib, sa, sb, s, ts, k, c;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= 32768) ? ia - 65536 : ia;
    sb = (ib >= 32768) ? ib - 65536 : ib;
    k  = (ia >= W) ? W : ia;
    s  = 0;
    e.err = 1'b0;
    e.lat = 1;
    case (op)
      8'h01: s = ia & ib;
      8'h02: s = ia | ib;
      8'h03: s = ia ^ ib;
      8'h04: s = ~ia;
      8'h05, 8'h07: begin
        c  = (op == 8'h07) ? int'(psr[0]) : 0;
        s  = ia + ib + c;
        ts = sa + sb + c;
        psr[0] = (s > 65535);
        psr[5] = (ts > 32767) || (ts < -32768);
      end
      8'h06: begin
        s = ia + ib;
        psr[0] = (s > 65535);
      end
      8'h09: begin
        s  = ia - ib;
        ts = sa - sb;
        psr[0] = (ia >= ib);
        psr[5] = (ts > 32767) || (ts < -32768);
      end
      8'h0B: begin
        s = ia - ib;
        psr[6] = (ia == ib);
        psr[2] = (ia < ib);
        psr[7] = (sa < sb);
      end
      8'h84, 8'h0C: begin s = ib << k; e.lat = 1 + k; end
      8'h08:        begin s = ib >> k; e.lat = 1 + k; end
      8'h0F:        begin s = sb >>> k; e.lat = 1 + k; end
      default: begin s = 0; e.err = 1'b1; end
    endcase
    e.rout  = s[15:0];
    e.flags = psr;
  endtask

  // Called right at a posedge; returns at the posedge where the op was taken.
  task automatic issue(input string nm, input logic [7:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    exp_t e;
    bit   rdy;
    int   guard;
    guard = 0;
    #1;
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.r1       = a;
    bus.r2       = b;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) begin
      fail_now($sformatf("accept timeout %s", nm));
    end else begin
      model(op, a, b, e);
      e.name  = nm;
      e.acc_t = $time;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    #1;
    bus.in_valid = 1'b0;
    bus.opcode   = 8'($urandom);
    bus.r1       = 16'($urandom);
    bus.r2       = 16'($urandom);
    repeat (n) @(posedge clk);
  endtask

  task automatic drain();
    int g;
    g = 0;
    idle(1);
    while (q.size() != 0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    if (q.size() != 0) begin
      fail_now("drain timeout");
      q.delete();
      head_seen = 1'b0;
    end
  endtask

  task automatic set_ready(input logic v);
    #1 bus.out_ready = v;
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (q.size() == 0) begin
        fail_now($sformatf("spurious out_valid rout=%0h", bus.rout));
      end else begin
        if (!head_seen) begin
          chk($sformatf("latency %s", q[0].name),
              32'(($time - q[0].acc_t + P/2) / P), 32'(q[0].lat));
          head_seen = 1'b1;
        end
        chk($sformatf("rout %s", q[0].name), 32'(bus.rout), 32'(q[0].rout));
        chk($sformatf("flags %s", q[0].name), 32'(bus.flags), 32'(q[0].flags));
        chk($sformatf("err %s", q[0].name), 32'(bus.err), 32'(q[0].err));
        if (bus.out_ready) begin
          $display("txn %-10s rout=%04h flags=%02h err=%0b", q[0].name, bus.rout, bus.flags,
                   bus.err);
          last_rout  = bus.rout;
          last_flags = bus.flags;
          last_err   = bus.err;
          void'(q.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.opcode    = 8'h00;
    bus.r1        = 16'h0;
    bus.r2        = 16'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset rout", 32'(bus.rout), 32'h0);
    chk("reset flags", 32'(bus.flags), 32'h0);
    chk("reset err", 32'(bus.err), 32'h0);
    chk("reset in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);

    issue("ADD_ovf", 8'h05, 16'h7FFF, 16'h0001);
    drain();
    chk("lit ADD_ovf rout", 32'(last_rout), 32'h8000);
    chk("lit ADD_ovf flags", 32'(last_flags), 32'h20);

    issue("ADD_cry", 8'h05, 16'hFFFF, 16'h0001);
    drain();
    chk("lit ADD_cry rout", 32'(last_rout), 32'h0000);
    chk("lit ADD_cry flags", 32'(last_flags), 32'h01);

    issue("ADDU", 8'h06, 16'hFFFF, 16'h0002);
    issue("ADDC", 8'h07, 16'h0000, 16'h0000);
    drain();
    chk("lit ADDC rout", 32'(last_rout), 32'h0001);
    chk("lit ADDC flags", 32'(last_flags), 32'h00);

    issue("ADD_setc", 8'h05, 16'hFFFF, 16'h0001);
    issue("CMP_neg", 8'h0B, 16'hFFFE, 16'h0001);
    drain();
    chk("lit CMP_neg rout", 32'(last_rout), 32'hFFFD);
    chk("lit CMP_neg flags", 32'(last_flags), 32'h81);
    issue("CMP_eq", 8'h0B, 16'h1234, 16'h1234);
    drain();
    chk("lit CMP_eq flags", 32'(last_flags), 32'h41);

    issue("ARSH3", 8'h0F, 16'h0003, 16'h8000);
    idle(0);
    @(negedge clk);
    chk("in_ready in SHIFT", 32'(bus.in_ready), 32'h0);
    @(negedge clk);
    chk("in_ready in SHIFT 2", 32'(bus.in_ready), 32'h0);
    @(posedge clk);
    drain();
    chk("lit ARSH3 rout", 32'(last_rout), 32'hF000);

    issue("LSH20", 8'h84, 16'd20, 16'hABCD);
    drain();
    chk("lit LSH20 rout", 32'(last_rout), 32'h0000);

    issue("AND", 8'h01, 16'hF0F0, 16'h3C3C);
    issue("OR", 8'h02, 16'hF0F0, 16'h0F01);
    issue("NOT", 8'h04, 16'h00FF, 16'h1111);
    issue("RSH4", 8'h08, 16'd4, 16'hF0F0);
    issue("ALSH1", 8'h0C, 16'd1, 16'h4001);
    issue("ARSH20", 8'h0F, 16'd20, 16'h8001);
    issue("ARSH5p", 8'h0F, 16'd5, 16'h7000);
    issue("RSH0", 8'h08, 16'd0, 16'h1234);
    issue("SUB", 8'h09, 16'h8000, 16'h0001);
    drain();
    chk("lit SUB rout", 32'(last_rout), 32'h7FFF);
    chk("lit SUB flags", 32'(last_flags), 32'h61);

    set_ready(1'b0);
    issue("XOR_hold", 8'h03, 16'h00FF, 16'h0F0F);
    idle(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold in_ready %0d", i), 32'(bus.in_ready), 32'h0);
      chk($sformatf("hold out_valid %0d", i), 32'(bus.out_valid), 32'h1);
    end
    @(posedge clk);
    set_ready(1'b1);
    drain();
    chk("lit XOR rout", 32'(last_rout), 32'h0FF0);

    issue("ILLEGAL", 8'hAA, 16'h1234, 16'h5678);
    drain();
    chk("lit ILLEGAL err", 32'(last_err), 32'h1);
    chk("lit ILLEGAL rout", 32'(last_rout), 32'h0000);
    chk("lit ILLEGAL flags", 32'(last_flags), 32'h61);

    issue("LSH9_rst", 8'h84, 16'd9, 16'h0001);
    idle(4);
    #1 reset = 1'b1;
    q.delete();
    head_seen = 1'b0;
    psr = 8'h00;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post-reset out_valid", 32'(bus.out_valid), 32'h0);
    chk("post-reset flags", 32'(bus.flags), 32'h0);
    chk("post-reset in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    idle(15);

    issue("ADDC_post", 8'h07, 16'h0001, 16'h0001);
    drain();
    chk("lit ADDC_post rout", 32'(last_rout), 32'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
